// File: rtl/seg7_scan_driver_if.sv
// Bundle between the hex display stage and the 7-segment scan driver.
// Carries the digit code, display controls and the pin-level outputs.
// Pure wiring with no latency; there is no backpressure on this path.
interface seg7_scan_driver_if;
    logic [15:0] led7_in;
    logic [3:0]  digit_en;
    logic        blink;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    // Upstream display stage: drives the code and controls, observes the pins
    modport master (
        output led7_in, digit_en, blink, brightness,
        input  an, seg, dp, digit_idx
    );

    // Scan driver: consumes the code and controls, drives the pins
    modport slave (
        input  led7_in, digit_en, blink, brightness,
        output an, seg, dp, digit_idx
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blanking, blink and PWM.
// an/seg are registered, 1 cycle behind the scan counters; inputs are latched once per frame.
// No backpressure: the inputs are sampled continuously and the pins are always driven.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic              clk_in,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [31:0] PWM_STEP = 32'(REFRESH_DIV / 8);

    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       en_shadow_q, en_shadow_d;
    logic [2:0]       bright_shadow_q, bright_shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             refresh_wrap;
    logic [31:0]      on_limit;
    logic             slot_on;
    logic             lit;
    logic [3:0]       nibble;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state for scan/blink counters, frame shadows and the pin image
    always_comb begin
        refresh_cnt_d   = refresh_cnt_q;
        digit_idx_d     = digit_idx_q;
        blink_cnt_d     = blink_cnt_q;
        blink_phase_d   = blink_phase_q;
        shadow_d        = shadow_q;
        en_shadow_d     = en_shadow_q;
        bright_shadow_d = bright_shadow_q;
        an_d            = 4'hF;
        seg_d           = 7'h7F;

        refresh_wrap = (refresh_cnt_q == REF_LAST);
        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 2'd1;
            // Latch only at the frame boundary so a frame never mixes old and new digits
            if (digit_idx_q == 2'd3) begin
                shadow_d        = bus.led7_in;
                en_shadow_d     = bus.digit_en;
                bright_shadow_d = bus.brightness;
            end
        end else begin
            refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        end

        // Blink state is parked at phase 0 while idle so the first half-period is visible
        if (!bus.blink) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end

        // Count 0 of every slot stays dark as dead time against ghosting between digits
        on_limit = ({29'd0, bright_shadow_q} + 32'd1) * PWM_STEP;
        slot_on  = (refresh_cnt_q != '0) && (32'(refresh_cnt_q) < on_limit);
        lit      = slot_on && en_shadow_q[digit_idx_q] && !(bus.blink && blink_phase_q);
        nibble   = shadow_q[{digit_idx_q, 2'b00} +: 4];

        if (lit) begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = hex_to_seg(nibble);
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            refresh_cnt_q   <= '0;
            digit_idx_q     <= 2'd0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
            shadow_q        <= 16'h0000;
            en_shadow_q     <= 4'h0;
            bright_shadow_q <= 3'd0;
            an_q            <= 4'hF;
            seg_q           <= 7'h7F;
        end else begin
            refresh_cnt_q   <= refresh_cnt_d;
            digit_idx_q     <= digit_idx_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            shadow_q        <= shadow_d;
            en_shadow_q     <= en_shadow_d;
            bright_shadow_q <= bright_shadow_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = 1'b1;
    assign bus.digit_idx = digit_idx_q;
endmodule
